// File: rtl/buyruk_bellegi.sv
// Instruction memory with a byte-serial program loader for the islemci fetch port.
// The core is held in reset and fed NOPs until a load completes.
module buyruk_bellegi #(
  parameter int unsigned DERINLIK = 256,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   ps,
  output logic [31:0]                   buyruk,
  input  logic                          yukle_basla,
  input  logic [7:0]                    yukle_veri,
  input  logic                          yukle_gecerli,
  output logic                          yukle_hazir,
  input  logic                          yukle_bitti,
  output logic                          islemci_rst,
  output logic [$clog2(DERINLIK):0]     kelime_say,
  output logic                          hizasiz_hata
);

  localparam int unsigned AW = $clog2(DERINLIK);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    YUKLE = 2'd1,
    CALIS = 2'd2
  } durum_t;

  durum_t       durum, durum_n;
  logic [23:0]  hold, hold_n;
  logic [1:0]   bayt_say;
  logic [2:0]   bayt_say_n;
  logic         kabul;
  logic         tam_kelime;
  logic         bosalt;
  logic         yaz_en;
  logic [31:0]  yaz_veri;
  logic         hizali;
  logic         adres_ok;
  logic         fetch_ok;

  logic [31:0]  mem [DERINLIK];

  assign yukle_hazir = (durum == YUKLE) && (kelime_say < CW'(DERINLIK));
  assign kabul       = yukle_gecerli && yukle_hazir;

  always_comb begin
    durum_n = durum;
    case (durum)
      BOSTA: if (yukle_basla) durum_n = YUKLE;
      YUKLE: begin
        if (yukle_basla)      durum_n = YUKLE;
        else if (yukle_bitti) durum_n = CALIS;
      end
      CALIS: if (yukle_basla) durum_n = YUKLE;
      default: durum_n = BOSTA;
    endcase
  end

  // The byte arriving with yukle_bitti is merged before the flush, and the
  // holding register is zeroed after each write so partial words carry zero upper bytes.
  always_comb begin
    hold_n     = hold;
    tam_kelime = 1'b0;
    if (kabul) begin
      case (bayt_say)
        2'd0:    hold_n[7:0]   = yukle_veri;
        2'd1:    hold_n[15:8]  = yukle_veri;
        2'd2:    hold_n[23:16] = yukle_veri;
        default: tam_kelime    = 1'b1;
      endcase
    end
    bayt_say_n = {1'b0, bayt_say} + {2'b00, kabul};
    bosalt     = (durum == YUKLE) && yukle_bitti && !yukle_basla &&
                 !tam_kelime && (bayt_say_n != 3'd0);
    yaz_en     = (durum == YUKLE) && !yukle_basla && (tam_kelime || bosalt);
    yaz_veri   = tam_kelime ? {yukle_veri, hold} : {8'h00, hold_n};
  end

  always_ff @(posedge clk) begin
    if (yaz_en) mem[kelime_say[AW-1:0]] <= yaz_veri;
  end

  assign hizali   = (ps[1:0] == 2'b00);
  assign adres_ok = ({2'b00, ps[31:2]} < 32'(kelime_say));
  assign fetch_ok = hizali && adres_ok;
  assign buyruk   = ((durum == CALIS) && fetch_ok) ? mem[ps[AW+1:2]] : NOP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum        <= BOSTA;
      islemci_rst  <= 1'b1;
      hold         <= '0;
      bayt_say     <= '0;
      kelime_say   <= '0;
      hizasiz_hata <= 1'b0;
    end else begin
      durum       <= durum_n;
      islemci_rst <= (durum_n != CALIS);
      if (yukle_basla) begin
        hold         <= '0;
        bayt_say     <= '0;
        kelime_say   <= '0;
        hizasiz_hata <= 1'b0;
      end else if (durum == YUKLE) begin
        if (tam_kelime || bosalt) begin
          hold       <= '0;
          bayt_say   <= '0;
          kelime_say <= kelime_say + 1'b1;
        end else if (kabul) begin
          hold     <= hold_n;
          bayt_say <= bayt_say_n[1:0];
        end
      end else if (durum == CALIS && !fetch_ok) begin
        hizasiz_hata <= 1'b1;
      end
    end
  end

endmodule

// File: doc/buyruk_bellegi.md
# buyruk_bellegi

Instruction memory and program loader that sits on the fetch side of `islemci`. It takes the processor's `ps` and returns `buyruk` combinationally, so the single-cycle core sees the instruction in the same cycle. A byte-serial loader port writes the program into memory with a valid/ready handshake. While the program is loading, the block holds the core in reset and feeds it NOPs.

## Interface
- `DERINLIK`, 256: memory depth in 32-bit words. Must be a power of two.
- `NOP`, 32'h0000_0013: word returned whenever no valid instruction is available (`addi x0,x0,0`).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ps` input 32: byte address from `islemci`.
- `buyruk` output 32: instruction word at `ps`; combinational.
- `yukle_basla` input 1: one-cycle pulse that starts or restarts a load.
- `yukle_veri` input 8: program byte, little-endian within each word.
- `yukle_gecerli` input 1: `yukle_veri` is valid.
- `yukle_hazir` output 1: the block will accept a byte this cycle.
- `yukle_bitti` input 1: one-cycle pulse that ends the load.
- `islemci_rst` output 1: registered reset to the core.
- `kelime_say` output log2(DERINLIK)+1: number of words written by the current load.
- `hizasiz_hata` output 1: sticky flag for a misaligned or out-of-range fetch.

## Operation
- **States:** BOSTA (idle after reset), YUKLE (loading), CALIS (core running).
- **Transitions:**
  - BOSTA→YUKLE on `yukle_basla`.
  - YUKLE→CALIS on `yukle_bitti`.
  - CALIS→YUKLE on `yukle_basla`.
  - YUKLE→YUKLE on `yukle_basla`: the load restarts.
  - Entering YUKLE clears the word counter, byte counter and `hizasiz_hata`.
- **Byte acceptance:** a byte is accepted on a rising edge where `yukle_gecerli && yukle_hazir`.
- **Ready:** `yukle_hazir` = (state==YUKLE) && (`kelime_say` < DERINLIK). It is combinational from registers.
- **Word assembly:** bytes fill a 24-bit holding register, with byte 0 in [7:0].
- **Word write:** on the 4th accepted byte, `mem[kelime_say]` <= {byte, hold[23:0]}. The byte counter then wraps to 0 and `kelime_say` increments.
- **Memory full:** when `kelime_say` == DERINLIK, `yukle_hazir` drops. Further bytes are not accepted, and the sender stalls.
- **End of load, partial word:** if `yukle_bitti` arrives with 1–3 bytes held, the partial word is written with its upper bytes zero, and `kelime_say` increments.
- **Same-cycle byte and end:** if `yukle_bitti` and an accepted byte occur in the same cycle, the byte is included before the flush/write.
- **Same-cycle start and end:** `yukle_basla` together with `yukle_bitti` gives priority to `yukle_basla`. The state stays in YUKLE with counters cleared.
- **Fetch:** in CALIS, `buyruk` = `mem[ps>>2]` when `ps[1:0]`==0 and `ps>>2` < `kelime_say`.
  - Otherwise in CALIS, `buyruk` = NOP.
  - In BOSTA and YUKLE, `buyruk` = NOP.
- **Fetch errors:**
  - A misaligned `ps` in CALIS sets `hizasiz_hata` on the next edge.
  - An out-of-range `ps` (beyond `kelime_say` words) in CALIS also sets it.
  - The flag stays set until `rst` or the next entry to YUKLE.
- **`islemci_rst`:** registered, = (next state != CALIS).
- **Reset:** the memory array has no reset and keeps its contents. An aborted load leaves partially written words in memory, but they are unreachable until a new load completes.

## Timing
- **Values during and after `rst`:**
  - state = BOSTA
  - `islemci_rst` = 1
  - `yukle_hazir` = 0
  - `kelime_say` = 0
  - `hizasiz_hata` = 0
  - `buyruk` = NOP
- **Reset mid-load or mid-run:** takes effect immediately (asynchronous). The state returns to BOSTA, and a partial word in the holding register is discarded.
- **Load start:** `yukle_hazir` goes high the cycle after `yukle_basla`.
- **Write visibility:** a written word is readable by fetch from the cycle after the write edge.
- **Handover to the core:**
  - `islemci_rst` falls on the edge that samples `yukle_bitti`.
  - The core's first fetch is at `ps`=0 one edge later.
  - `islemci_rst` rises on the edge that samples a `yukle_basla` issued in CALIS.
- **Fetch latency:** zero cycles from `ps` to `buyruk`. There is no registered read path.
- **Throughput:** one byte per cycle maximum; four cycles per word.

## Test plan
- **Basic load and run:** reset, pulse `yukle_basla`, send bytes 13 05 50 00 93 05 A0 00, pulse `yukle_bitti`.
  - `kelime_say`=2.
  - `islemci_rst` falls.
  - `ps`=0 gives `buyruk`=32'h0050_0513.
  - `ps`=4 gives `buyruk`=32'h00A0_0593.
  - `ps`=8 gives NOP.
- **Partial word:** send 5 bytes 01 02 03 04 AA, then `yukle_bitti` → `mem[1]`=32'h0000_00AA and `kelime_say`=2.
- **Full memory, DERINLIK=4:** stream 20 bytes with `yukle_gecerli` held high → `yukle_hazir` falls after byte 16, bytes 17–20 are not accepted, and `kelime_say`=4.
- **Misaligned fetch:** in CALIS drive `ps`=32'h6 → `buyruk`=NOP and `hizasiz_hata`=1 on the next edge. The flag stays set, and `yukle_basla` clears it.
- **Reload while running:** pulse `yukle_basla` in CALIS → `islemci_rst`=1 on the next edge, `buyruk`=NOP, `kelime_say`=0. New bytes overwrite from word 0.
- **Async reset mid-load:** assert `rst` between clock edges after 6 bytes → outputs take their reset values immediately. After reset, `ps`=0 returns NOP.
